// File: rtl/seq_detect_pkg.sv
// Shared types, constants and helpers for the parametrised serial pattern detector.
// The border helper is used when an overlapping match hands progress back to the matcher.
package seq_detect_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam int MODE_MEALY  = 0;
    localparam int MODE_MOORE  = 1;

    // Longest proper border of the first-received-first (MSB-first) pattern of length len.
    function automatic logic [4:0] border_len(input logic [15:0] pattern, input int len);
        logic [15:0] mask;
        logic [4:0]  best;
        best = 5'd0;
        for (int k = 1; k < MAX_PAT_LEN; k++) begin
            mask = (16'd1 << k) - 16'd1;
            if (k < len) begin
                if (((pattern >> (len - k)) & mask) == (pattern & mask)) begin
                    best = 5'(k);
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational next-state and match evaluation for the prefix-tracking detector.
// On a mismatch the state falls back to the longest suffix that is still a pattern prefix.
module seq_prefix_match
    import seq_detect_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int ST_W    = $clog2(PAT_LEN + 1)
) (
    input  logic [ST_W-1:0]    state,
    input  logic               seq_bit,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    output logic [ST_W-1:0]    next_state,
    output logic               hit
);

    logic [PAT_LEN-1:0] cand_s;
    logic [PAT_LEN-1:0] mask_s;
    logic [ST_W-1:0]    fall_s;
    logic [ST_W-1:0]    border_s;
    int                 len_s;

    assign border_s = ST_W'(border_len(16'(pattern), PAT_LEN));

    // Candidate = matched prefix followed by the new bit; search its longest prefix-suffix.
    always_comb begin
        len_s  = int'(state) + 1;
        cand_s = ((pattern >> (PAT_LEN - int'(state))) << 1) | PAT_LEN'(seq_bit);
        hit    = (len_s == PAT_LEN) && (cand_s == pattern);
        fall_s = '0;
        mask_s = '0;
        for (int k = 1; k < PAT_LEN; k++) begin
            mask_s = (PAT_LEN'(1) << k) - PAT_LEN'(1);
            if ((k <= len_s) && (((pattern >> (PAT_LEN - k)) & mask_s) == (cand_s & mask_s))) begin
                fall_s = ST_W'(k);
            end else begin
                fall_s = fall_s;
            end
        end
        if (hit) begin
            next_state = overlap ? border_s : '0;
        end else begin
            next_state = fall_s;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with runtime pattern load, overlap select
// and a saturating match counter; Mealy or Moore match pulse.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
    parameter int                 MOORE       = 0,
    parameter int                 CNT_W       = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic                         i_seq,
    input  logic                         i_load,
    input  logic [PAT_LEN-1:0]           i_pattern,
    input  logic                         i_overlap,
    input  logic                         i_clr_cnt,
    output logic                         o_out,
    output logic [CNT_W-1:0]             o_cnt,
    output logic [$clog2(PAT_LEN+1)-1:0] o_state
);

    localparam int               ST_W    = $clog2(PAT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] pattern_r;
    logic [ST_W-1:0]    state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               moore_out_r;
    logic [ST_W-1:0]    next_state_s;
    logic               hit_s;
    logic               accept_s;
    logic               match_s;

    seq_prefix_match #(
        .PAT_LEN (PAT_LEN),
        .ST_W    (ST_W)
    ) u_match (
        .state      (state_r),
        .seq_bit    (i_seq),
        .pattern    (pattern_r),
        .overlap    (i_overlap),
        .next_state (next_state_s),
        .hit        (hit_s)
    );

    // A load cycle drops its bit; reset masks the combinational pulse as well.
    assign accept_s = i_en & ~i_load & ~i_rst;
    assign match_s  = accept_s & hit_s;

    // Pattern, prefix state, saturating counter and the registered match pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pattern_r   <= DEFAULT_PAT;
            state_r     <= '0;
            cnt_r       <= '0;
            moore_out_r <= 1'b0;
        end else begin
            if (i_load) begin
                pattern_r <= i_pattern;
                state_r   <= '0;
            end else if (i_en) begin
                state_r <= next_state_s;
            end else begin
                state_r <= state_r;
            end
            if (i_clr_cnt) begin
                cnt_r <= match_s ? CNT_W'(1) : '0;
            end else if (match_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            moore_out_r <= match_s;
        end
    end

    assign o_out   = (MOORE == MODE_MEALY) ? match_s : moore_out_r;
    assign o_cnt   = cnt_r;
    assign o_state = state_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: Mealy/8-bit, Moore/8-bit and Mealy/2-bit-counter detectors share one stimulus.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       seq = 1'b0;
    logic       load = 1'b0;
    logic       overlap = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] pattern = 4'b0000;

    logic       out_m, out_mo, out_s;
    logic [7:0] cnt_m, cnt_mo;
    logic [1:0] cnt_s;
    logic [2:0] st_m, st_mo, st_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .MOORE(0), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_seq(seq), .i_load(load), .i_pattern(pattern),
        .i_overlap(overlap), .i_clr_cnt(clr), .o_out(out_m), .o_cnt(cnt_m), .o_state(st_m));

    seq_detect_param #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .MOORE(1), .CNT_W(8)) dut_moore (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_seq(seq), .i_load(load), .i_pattern(pattern),
        .i_overlap(overlap), .i_clr_cnt(clr), .o_out(out_mo), .o_cnt(cnt_mo), .o_state(st_mo));

    seq_detect_param #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .MOORE(0), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_seq(seq), .i_load(load), .i_pattern(pattern),
        .i_overlap(overlap), .i_clr_cnt(clr), .o_out(out_s), .o_cnt(cnt_s), .o_state(st_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Mealy pulse is sampled mid-cycle; state and Moore pulse just after the edge.
    task automatic step(input string tag, input logic s_en, input logic s_seq, input logic s_load,
                        input logic s_rst, input logic s_clr, input logic exp_out, input int exp_st);
        @(negedge clk);
        en = s_en; seq = s_seq; load = s_load; rst = s_rst; clr = s_clr;
        #1;
        check({tag, "/mealy_out"}, 32'(out_m), 32'(exp_out));
        @(posedge clk);
        #1;
        check({tag, "/state"}, 32'(st_m), 32'(exp_st));
        check({tag, "/moore_out"}, 32'(out_mo), 32'(exp_out));
    endtask

    task automatic feed(input string tag, input logic s_seq, input logic exp_out, input int exp_st);
        step(tag, 1'b1, s_seq, 1'b0, 1'b0, 1'b0, exp_out, exp_st);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        check({tag, "/cnt"}, 32'(cnt_m), 32'd0);
        check({tag, "/cnt_sat"}, 32'(cnt_s), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [3:0] pat);
        pattern = pat;
        step(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        // 1: pattern 1011, overlapping
        do_reset("t1.rst");
        overlap = 1'b1;
        feed("t1.b1", 1'b1, 1'b0, 1);
        feed("t1.b2", 1'b0, 1'b0, 2);
        feed("t1.b3", 1'b1, 1'b0, 3);
        feed("t1.b4", 1'b1, 1'b1, 1);
        feed("t1.b5", 1'b0, 1'b0, 2);
        feed("t1.b6", 1'b1, 1'b0, 3);
        feed("t1.b7", 1'b1, 1'b1, 1);
        check("t1.cnt", 32'(cnt_m), 32'd2);
        check("t1.cnt_sat", 32'(cnt_s), 32'd2);

        // 2: same stream, non-overlapping; bits 5..7 (0,1,1) end with KMP state 1
        do_reset("t2.rst");
        overlap = 1'b0;
        feed("t2.b1", 1'b1, 1'b0, 1);
        feed("t2.b2", 1'b0, 1'b0, 2);
        feed("t2.b3", 1'b1, 1'b0, 3);
        feed("t2.b4", 1'b1, 1'b1, 0);
        feed("t2.b5", 1'b0, 1'b0, 0);
        feed("t2.b6", 1'b1, 1'b0, 1);
        feed("t2.b7", 1'b1, 1'b0, 1);
        check("t2.cnt", 32'(cnt_m), 32'd1);

        // 3: pattern 1111, seven ones, overlapping then non-overlapping
        do_reset("t3.rst");
        overlap = 1'b1;
        do_load("t3.load", 4'b1111);
        feed("t3.b1", 1'b1, 1'b0, 1);
        feed("t3.b2", 1'b1, 1'b0, 2);
        feed("t3.b3", 1'b1, 1'b0, 3);
        feed("t3.b4", 1'b1, 1'b1, 3);
        feed("t3.b5", 1'b1, 1'b1, 3);
        feed("t3.b6", 1'b1, 1'b1, 3);
        feed("t3.b7", 1'b1, 1'b1, 3);
        check("t3.cnt", 32'(cnt_m), 32'd4);
        check("t3.cnt_moore", 32'(cnt_mo), 32'd4);
        check("t3.cnt_sat", 32'(cnt_s), 32'd3);
        do_reset("t3n.rst");
        overlap = 1'b0;
        do_load("t3n.load", 4'b1111);
        feed("t3n.b1", 1'b1, 1'b0, 1);
        feed("t3n.b2", 1'b1, 1'b0, 2);
        feed("t3n.b3", 1'b1, 1'b0, 3);
        feed("t3n.b4", 1'b1, 1'b1, 0);
        feed("t3n.b5", 1'b1, 1'b0, 1);
        feed("t3n.b6", 1'b1, 1'b0, 2);
        feed("t3n.b7", 1'b1, 1'b0, 3);
        check("t3n.cnt", 32'(cnt_m), 32'd1);

        // 4: disabled cycles are ignored even with toggling data
        do_reset("t4.rst");
        overlap = 1'b1;
        feed("t4.b1", 1'b1, 1'b0, 1);
        feed("t4.b2", 1'b0, 1'b0, 2);
        step("t4.idle1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        step("t4.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        feed("t4.b3", 1'b1, 1'b0, 3);
        feed("t4.b4", 1'b1, 1'b1, 1);
        step("t4.idle3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check("t4.cnt", 32'(cnt_m), 32'd1);

        // 5: reset mid-sequence, then a load that swallows the completing bit
        do_reset("t5.rst");
        feed("t5.b1", 1'b1, 1'b0, 1);
        feed("t5.b2", 1'b0, 1'b0, 2);
        feed("t5.b3", 1'b1, 1'b0, 3);
        step("t5.midrst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        feed("t5.b4", 1'b1, 1'b0, 1);
        check("t5.cnt_a", 32'(cnt_m), 32'd0);
        feed("t5.b5", 1'b0, 1'b0, 2);
        feed("t5.b6", 1'b1, 1'b0, 3);
        pattern = 4'b1011;
        step("t5.loadbit", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("t5.cnt_b", 32'(cnt_m), 32'd0);
        feed("t5.c1", 1'b1, 1'b0, 1);
        feed("t5.c2", 1'b0, 1'b0, 2);
        feed("t5.c3", 1'b1, 1'b0, 3);
        feed("t5.c4", 1'b1, 1'b1, 1);
        check("t5.cnt_c", 32'(cnt_m), 32'd1);

        // 6: saturation, clear coincident with a match, overlap changed on the fly
        do_reset("t6.rst");
        overlap = 1'b1;
        do_load("t6.load", 4'b1111);
        feed("t6.b1", 1'b1, 1'b0, 1);
        feed("t6.b2", 1'b1, 1'b0, 2);
        feed("t6.b3", 1'b1, 1'b0, 3);
        for (int i = 4; i <= 10; i++) begin
            feed("t6.bn", 1'b1, 1'b1, 3);
        end
        check("t6.cnt", 32'(cnt_m), 32'd7);
        check("t6.cnt_sat", 32'(cnt_s), 32'd3);
        step("t6.clrhit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        check("t6.cnt_clrhit", 32'(cnt_m), 32'd1);
        check("t6.cnt_sat_clrhit", 32'(cnt_s), 32'd1);
        step("t6.clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        check("t6.cnt_clr", 32'(cnt_m), 32'd0);
        overlap = 1'b0;
        feed("t6.novl", 1'b1, 1'b1, 0);
        check("t6.cnt_novl", 32'(cnt_m), 32'd1);
        check("t6.cnt_sat_novl", 32'(cnt_s), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
